// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the floating-point operand path:
//                opcode encodings, default field widths, the per-operand
//                classification flag struct and the opcode decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Default IEEE-754 single-precision field widths
    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    // Operation codes
    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_MUL   = 2'b01;
    localparam logic [1:0] OP_INV_S = 2'b10;
    localparam logic [1:0] OP_ABS_W = 2'b11;

    // Per-operand classification, shared with the preliminary-result stage
    typedef struct packed {
        logic sign;
        logic val;
        logic nan;
        logic inf;
        logic zero;
        logic snan;
    } fp_flags_t;

    // One-hot opcode decode, packed as {MUL, INV_S, ABS_W, IDLE}
    function automatic logic [3:0] op_decode(input logic [1:0] op);
        op_decode = 4'b0001;
        case (op)
            OP_MUL:   op_decode = 4'b1000;
            OP_INV_S: op_decode = 4'b0100;
            OP_ABS_W: op_decode = 4'b0010;
            default:  op_decode = 4'b0001;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational classifier/unpacker for one packed operand.
//                Subnormals are flushed to zero with their sign kept.
//  Ports       : i_op    - packed operand {sign, exp, frac}
//                o_flags - sign/val/nan/inf/zero/snan classification
//                o_exp   - biased exponent, 0 for zero/subnormal
//                o_man   - {hidden bit, frac} for normal values, else 0
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output fp_flags_t            o_flags,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_man
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_frac;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_frac_nz;

    assign w_exp      = i_op[EXP_W+MAN_W-1:MAN_W];
    assign w_frac     = i_op[MAN_W-1:0];
    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_frac_nz  = |w_frac;

    always_comb begin
        o_flags      = '0;
        o_flags.sign = i_op[EXP_W+MAN_W];
        o_flags.nan  = w_exp_ones & w_frac_nz;
        o_flags.inf  = w_exp_ones & ~w_frac_nz;
        o_flags.zero = w_exp_zero;
        o_flags.val  = ~w_exp_ones & ~w_exp_zero;
        // Quiet bit clear on a NaN marks it as signalling
        o_flags.snan = w_exp_ones & w_frac_nz & ~w_frac[MAN_W-1];
    end

    assign o_exp = w_exp_zero ? '0 : w_exp;
    assign o_man = (~w_exp_ones & ~w_exp_zero) ? {1'b1, w_frac} : '0;

endmodule
`default_nettype wire

// File: rtl/fp_operand_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_operand_unpack
//  Description : Two-stage pipelined operand unpacker/classifier.
//                Stage 1 registers raw operands and opcode; stage 2 registers
//                classification flags, unpacked exp/mantissa and the one-hot
//                opcode strobes. Keeps a sticky signalling-NaN flag.
//  Ports       : in_valid/in_ready   - upstream handshake
//                op_a/op_b/op_code   - packed operands and operation
//                out_valid/out_ready - downstream handshake
//                operand_*_*, exp_*, man_*, MUL/INV_S/ABS_W/IDLE - results
//                clr_flags/sticky_invalid - sticky invalid-operand flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] op_a,
    input  logic [EXP_W+MAN_W:0] op_b,
    input  logic [1:0]           op_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 operand_A_sign,
    output logic                 operand_A_val,
    output logic                 operand_A_NAN,
    output logic                 operand_A_INF,
    output logic                 operand_A_ZERO,
    output logic                 operand_B_sign,
    output logic                 operand_B_val,
    output logic                 operand_B_NAN,
    output logic                 operand_B_INF,
    output logic                 operand_B_ZERO,
    output logic [EXP_W-1:0]     exp_a,
    output logic [EXP_W-1:0]     exp_b,
    output logic [MAN_W:0]       man_a,
    output logic [MAN_W:0]       man_b,
    output logic                 MUL,
    output logic                 INV_S,
    output logic                 ABS_W,
    output logic                 IDLE,
    input  logic                 clr_flags,
    output logic                 sticky_invalid
);

    localparam int c_OP_W = EXP_W + MAN_W + 1;

    // Stage 1: raw operands
    logic              r_s1_valid;
    logic [c_OP_W-1:0] r_s1_a;
    logic [c_OP_W-1:0] r_s1_b;
    logic [1:0]        r_s1_op;

    // Stage 2: classified results; flags packed {sign, val, nan, inf, zero}
    logic              r_out_valid;
    logic [4:0]        r_flags_a;
    logic [4:0]        r_flags_b;
    logic [EXP_W-1:0]  r_exp_a;
    logic [EXP_W-1:0]  r_exp_b;
    logic [MAN_W:0]    r_man_a;
    logic [MAN_W:0]    r_man_b;
    logic [3:0]        r_dec;
    logic              r_sticky;

    fp_flags_t         w_cls_a;
    fp_flags_t         w_cls_b;
    logic [EXP_W-1:0]  w_exp_a;
    logic [EXP_W-1:0]  w_exp_b;
    logic [MAN_W:0]    w_man_a;
    logic [MAN_W:0]    w_man_b;
    logic              w_s1_adv;
    logic              w_in_fire;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .i_op    (r_s1_a),
        .o_flags (w_cls_a),
        .o_exp   (w_exp_a),
        .o_man   (w_man_a)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .i_op    (r_s1_b),
        .o_flags (w_cls_b),
        .o_exp   (w_exp_b),
        .o_man   (w_man_b)
    );

    // Stage 1 moves into stage 2 whenever stage 2 is empty or being drained
    assign w_s1_adv  = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_op     <= OP_IDLE;
            r_out_valid <= 1'b0;
            r_flags_a   <= '0;
            r_flags_b   <= '0;
            r_exp_a     <= '0;
            r_exp_b     <= '0;
            r_man_a     <= '0;
            r_man_b     <= '0;
            r_dec       <= 4'b0001;
            r_sticky    <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= op_a;
                r_s1_b     <= op_b;
                r_s1_op    <= op_code;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_flags_a   <= {w_cls_a.sign, w_cls_a.val, w_cls_a.nan, w_cls_a.inf, w_cls_a.zero};
                r_flags_b   <= {w_cls_b.sign, w_cls_b.val, w_cls_b.nan, w_cls_b.inf, w_cls_b.zero};
                r_exp_a     <= w_exp_a;
                r_exp_b     <= w_exp_b;
                r_man_a     <= w_man_a;
                r_man_b     <= w_man_b;
                r_dec       <= op_decode(r_s1_op);
            end else if (out_ready) begin
                // Drained with nothing behind it: strobes fall back to IDLE
                r_out_valid <= 1'b0;
                r_dec       <= 4'b0001;
            end

            // Set has priority over clear
            if (w_s1_adv && (w_cls_a.snan || w_cls_b.snan)) begin
                r_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign operand_A_sign = r_flags_a[4];
    assign operand_A_val  = r_flags_a[3];
    assign operand_A_NAN  = r_flags_a[2];
    assign operand_A_INF  = r_flags_a[1];
    assign operand_A_ZERO = r_flags_a[0];
    assign operand_B_sign = r_flags_b[4];
    assign operand_B_val  = r_flags_b[3];
    assign operand_B_NAN  = r_flags_b[2];
    assign operand_B_INF  = r_flags_b[1];
    assign operand_B_ZERO = r_flags_b[0];
    assign exp_a          = r_exp_a;
    assign exp_b          = r_exp_b;
    assign man_a          = r_man_a;
    assign man_b          = r_man_b;
    assign MUL            = r_dec[3];
    assign INV_S          = r_dec[2];
    assign ABS_W          = r_dec[1];
    assign IDLE           = r_dec[0];
    assign sticky_invalid = r_sticky;

endmodule
`default_nettype wire
